// File: rtl/prod_bcd_pkg.sv
// rtl/prod_bcd_pkg.sv - shared types and constants for the product BCD converter
// Contents:
//   state_t    converter FSM states
//   BCD_NIBBLE bits per BCD digit
//   SEG7_LUT   active-low {g..a} patterns for digits 0..9
//   SEG_BLANK  all segments off
package prod_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam int BCD_NIBBLE = 4;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG7_LUT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - one BCD digit to active-low seven-segment pattern
// Ports:
//   digit_i  in  4  BCD digit
//   seg_o    out 7  active-low segments {g..a}; codes above 9 show blank
module bcd_to_seg7
    import prod_bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (digit_i <= 4'd9) begin
            seg_o = SEG7_LUT[digit_i];
        end
    end

endmodule

// File: rtl/product_bcd_converter.sv
// rtl/product_bcd_converter.sv - captures multiplier products and converts them to packed BCD
// Optional feature: SEG7_DISPLAY_EN adds a registered seven-segment output.
// Ports:
//   clk      in   1         system clock, rising edge
//   reset    in   1         asynchronous active-low reset
//   product  in   WIDTH     binary value from the multiplier
//   valid    in   1         result-valid; a rising edge triggers one conversion
//   bcd      out  4*DIGITS  packed BCD, ones digit in [3:0]
//   done     out  1         one-cycle pulse when bcd updates
//   busy     out  1         conversion in progress
//   overrun  out  1         sticky; a pending value was overwritten
//   seg      out  7*DIGITS  (SEG7_DISPLAY_EN only) active-low segments, digit0 in [6:0]
module product_bcd_converter
    import prod_bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [WIDTH-1:0]             product,
    input  logic                         valid,
    output logic [BCD_NIBBLE*DIGITS-1:0] bcd,
    output logic                         done,
    output logic                         busy,
`ifdef SEG7_DISPLAY_EN
    output logic [7*DIGITS-1:0]          seg,
`endif
    output logic                         overrun
);

    localparam int BCD_W = BCD_NIBBLE * DIGITS;
    localparam int SR_W  = BCD_W + WIDTH;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_SHIFT = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   pend_q, pend_d;
    logic               pend_full_q, pend_full_d;
    logic               overrun_q, overrun_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               done_q, done_d;
    logic               valid_q;
    logic               rise;
    logic [SR_W-1:0]    sr_adj;

    assign rise = valid & ~valid_q;

    // Double-dabble correction: any BCD nibble >= 5 gets +3 before the shift,
    // so the doubled value carries correctly into the next decimal digit.
    assign sr_adj[WIDTH-1:0] = sr_q[WIDTH-1:0];
    for (genvar d = 0; d < DIGITS; d++) begin : g_add3
        logic [3:0] nib;
        assign nib = sr_q[WIDTH + BCD_NIBBLE*d +: BCD_NIBBLE];
        assign sr_adj[WIDTH + BCD_NIBBLE*d +: BCD_NIBBLE] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = overrun_q;
        bcd_d       = bcd_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    sr_d    = {{BCD_W{1'b0}}, product};
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = sr_adj << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_SHIFT) begin
                    state_d = FINISH;
                end
                if (rise) begin
                    pend_d      = product;
                    pend_full_d = 1'b1;
                    if (pend_full_q) begin
                        overrun_d = 1'b1;
                    end
                end
            end
            FINISH: begin
                bcd_d  = sr_q[WIDTH +: BCD_W];
                done_d = 1'b1;
                cnt_d  = '0;
                // Back-to-back restart: the older pending value goes first,
                // a coincident new value takes its place in the buffer.
                if (pend_full_q) begin
                    sr_d    = {{BCD_W{1'b0}}, pend_q};
                    state_d = SHIFT;
                    if (rise) begin
                        pend_d = product;
                    end else begin
                        pend_full_d = 1'b0;
                    end
                end else if (rise) begin
                    sr_d    = {{BCD_W{1'b0}}, product};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            cnt_q       <= '0;
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            overrun_q   <= 1'b0;
            bcd_q       <= '0;
            done_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_full_q <= pend_full_d;
            overrun_q   <= overrun_d;
            bcd_q       <= bcd_d;
            done_q      <= done_d;
            valid_q     <= valid;
        end
    end

    assign bcd     = bcd_q;
    assign done    = done_q;
    assign busy    = (state_q != IDLE);
    assign overrun = overrun_q;

`ifdef SEG7_DISPLAY_EN
    logic [7*DIGITS-1:0] seg_next;
    logic [7*DIGITS-1:0] seg_q;

    for (genvar d = 0; d < DIGITS; d++) begin : g_seg
        bcd_to_seg7 u_bcd_to_seg7 (
            .digit_i (sr_q[WIDTH + BCD_NIBBLE*d +: BCD_NIBBLE]),
            .seg_o   (seg_next[7*d +: 7])
        );
    end

    // Decoded from the same field and on the same edge as bcd.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            seg_q <= {DIGITS{SEG_BLANK}};
        end else if (state_q == FINISH) begin
            seg_q <= seg_next;
        end
    end

    assign seg = seg_q;
`endif

endmodule

// File: tb/tb_product_bcd_converter.sv
// tb/tb_product_bcd_converter.sv - scoreboard bench for product_bcd_converter
module tb_product_bcd_converter;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  product = 8'h00;
    logic        valid = 1'b0;
    logic [11:0] bcd;
    logic        done;
    logic        busy;
    logic        overrun;
`ifdef SEG7_DISPLAY_EN
    logic [20:0] seg;
`endif

    product_bcd_converter #(.WIDTH(8), .DIGITS(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .product (product),
        .valid   (valid),
        .bcd     (bcd),
        .done    (done),
        .busy    (busy),
`ifdef SEG7_DISPLAY_EN
        .seg     (seg),
`endif
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return 12'((((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
    endfunction

    function automatic logic [20:0] to_seg(input logic [11:0] b);
        logic [6:0] lut [0:9];
        logic [20:0] r;
        lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        for (int d = 0; d < 3; d++) begin
            r[7*d +: 7] = lut[b[4*d +: 4]];
        end
        return r;
    endfunction

    typedef struct {
        logic [11:0] bcd;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Timeline model: one conversion occupies 9 edges from trigger to done,
    // with a single-slot pending buffer behind it.
    int   cyc = 0;
    bit   m_active = 0;
    int   m_left = 0;
    bit   m_pend_v = 0;
    int   m_pend = 0;
    bit   m_ovr = 0;
    bit   m_prev_v = 0;

    task automatic m_start(input int v);
        exp_t e;
        m_active = 1;
        m_left = 9;
        e.bcd = to_bcd(v);
        e.cyc = cyc + 9;
        sb.push_back(e);
    endtask

    always @(posedge clk or negedge reset) begin
        bit r;
        if (!reset) begin
            m_active = 0;
            m_left = 0;
            m_pend_v = 0;
            m_ovr = 0;
            m_prev_v = 0;
            sb.delete();
        end else begin
            cyc++;
            r = valid && !m_prev_v;
            m_prev_v = valid;
            if (m_active && m_left == 1) begin
                m_active = 0;
                if (m_pend_v) begin
                    m_start(m_pend);
                    if (r) m_pend = int'(product);
                    else m_pend_v = 0;
                end else if (r) begin
                    m_start(int'(product));
                end
            end else if (m_active) begin
                m_left--;
                if (r) begin
                    if (m_pend_v) m_ovr = 1;
                    m_pend = int'(product);
                    m_pend_v = 1;
                end
            end else if (r) begin
                m_start(int'(product));
            end
        end
    end

    logic [11:0] hold = 12'h000;
    logic [20:0] seg_hold = 21'h1FFFFF;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            hold = 12'h000;
            seg_hold = 21'h1FFFFF;
        end else begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("done_bcd", 32'(bcd), 32'(e.bcd));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                    hold = e.bcd;
                    seg_hold = to_seg(e.bcd);
                end
            end else begin
                chk("bcd_hold", 32'(bcd), 32'(hold));
            end
            chk("busy", 32'(busy), 32'(m_active));
            chk("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SEG7_DISPLAY_EN
            chk("seg", 32'(seg), 32'(seg_hold));
`endif
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [7:0] v);
        @(negedge clk);
        valid = 1'b1;
        product = v;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_bcd", 32'(bcd), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_overrun", 32'(overrun), 32'(0));
`ifdef SEG7_DISPLAY_EN
        chk("rst_seg", 32'(seg), 32'h1FFFFF);
`endif
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 reset = 1'b0;
        #1 check_reset_outputs();
        valid = 1'b0;
        idle(2);
        @(posedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && (m_active || sb.size() > 0); i++) begin
            @(negedge clk);
        end
        chk("drain_queue", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        #3 check_reset_outputs();
        @(posedge clk);
        #2 reset = 1'b1;

        pulse(8'h00);
        drain();
        idle(2);

        @(negedge clk);
        valid = 1'b1;
        product = 8'hFF;
        idle(20);
        valid = 1'b0;
        drain();

        pulse(8'h0F);
        idle(2);
        pulse(8'h7B);
        drain();

        pulse(8'h01);
        idle(1);
        pulse(8'h02);
        idle(1);
        pulse(8'h03);
        drain();
        chk("overrun_sticky", 32'(overrun), 32'(1));
        do_reset();
        chk("overrun_cleared", 32'(overrun), 32'(0));

        pulse(8'h2A);
        idle(8);
        pulse(8'h63);
        drain();

        pulse(8'hC8);
        idle(3);
        do_reset();
        pulse(8'hC8);
        drain();

        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            valid = ($urandom_range(0, 9) < 3);
            product = 8'($urandom);
        end
        @(negedge clk);
        valid = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
